// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo}; latency DATA_W+1 (div-by-zero 2, fast multiply 2).
// No backpressure on the result: ready_o pulses once; stallReq holds the pipeline while an op is in flight.
module ex_muldiv #(
    parameter int DATA_W   = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                div_by_zero_o,
    output logic                busy_o,
    output logic                stallReq
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic                dz_q, dz_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                accept;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff;
    logic                load_res;
    logic [2*DATA_W-1:0] fix_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        dz_d     = dz_q;
        result_d = result_q;
        load_res = 1'b0;
        fix_res  = '0;

        accept = (state_q == IDLE) && start_i && !annul_i;
        a_neg  = !op_i[0] && opdata1_i[DATA_W-1];
        b_neg  = !op_i[0] && opdata2_i[DATA_W-1];
        a_mag  = a_neg ? -opdata1_i : opdata1_i;
        b_mag  = b_neg ? -opdata2_i : opdata2_i;

        // Shift-add step: {hi, lo} holds partial product and remaining multiplier bits.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
        // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
        div_sh   = {hi_q, lo_q[DATA_W-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh[DATA_W-1:0] - opb_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_div_d = op_i[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    opb_d    = b_mag;
                    if (op_i[1] && (opdata2_i == '0)) begin
                        hi_d     = opdata1_i;
                        lo_d     = '1;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = DZERO;
                    end else if (MUL_FAST && !op_i[1]) begin
                        // Product is complete now; one RUN cycle remains to hit the 2-cycle latency.
                        {hi_d, lo_d} = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
                        cnt_d        = LAST;
                        state_d      = RUN;
                    end else begin
                        hi_d    = '0;
                        lo_d    = a_mag;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    hi_d = div_ge ? div_diff : div_sh[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], div_ge};
                end else if (!MUL_FAST) begin
                    hi_d = mul_sum[DATA_W:1];
                    lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    dz_d     = 1'b0;
                    load_res = 1'b1;
                end
            end
            DZERO: begin
                state_d  = DONE;
                dz_d     = 1'b1;
                load_res = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (annul_i) begin
            state_d  = IDLE;
            dz_d     = dz_q;
            load_res = 1'b0;
        end

        if (is_div_q) begin
            fix_res = {(neg_hi_q ? -hi_d : hi_d), (neg_lo_q ? -lo_d : lo_d)};
        end else begin
            fix_res = neg_lo_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        end
        if (load_res) begin
            result_d = fix_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign result_o      = result_q;
    assign ready_o       = (state_q == DONE);
    assign div_by_zero_o = (state_q == DONE) && dz_q;
    assign busy_o        = (state_q == RUN);
    assign stallReq      = accept || (state_q == RUN) || (state_q == DZERO);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a slow (iterative) and a fast-multiply instance, each with its own stimulus.
module tb_ex_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [2];
    logic [1:0]  op    [2];
    logic [31:0] d1    [2];
    logic [31:0] d2    [2];
    logic        annul [2];
    logic [63:0] res   [2];
    logic        rdy   [2];
    logic        dzo   [2];
    logic        busy  [2];
    logic        stall [2];

    int checks   = 0;
    int failures = 0;

    ex_muldiv #(.DATA_W(32), .MUL_FAST(1'b0)) u_slow (
        .clk(clk), .rst(rst), .start_i(start[0]), .op_i(op[0]),
        .opdata1_i(d1[0]), .opdata2_i(d2[0]), .annul_i(annul[0]),
        .result_o(res[0]), .ready_o(rdy[0]), .div_by_zero_o(dzo[0]),
        .busy_o(busy[0]), .stallReq(stall[0])
    );

    ex_muldiv #(.DATA_W(32), .MUL_FAST(1'b1)) u_fast (
        .clk(clk), .rst(rst), .start_i(start[1]), .op_i(op[1]),
        .opdata1_i(d1[1]), .opdata2_i(d2[1]), .annul_i(annul[1]),
        .result_o(res[1]), .ready_o(rdy[1]), .div_by_zero_o(dzo[1]),
        .busy_o(busy[1]), .stallReq(stall[1])
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        exp_dz;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero like the ISA.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (o)
            2'b00: begin
                sq = sa * sb;
                r  = sq;
            end
            2'b01: begin
                uq = ua * ub;
                r  = uq;
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return {1'b0, r};
    endfunction

    // Called #1 after a rising edge with the selected instance idle.
    task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic exp_dz, input logic hold, input string name);
        int   lat;
        int   exp_lat;
        logic stall_ok;
        if (o[1] && b == 32'd0)    exp_lat = 2;
        else if (!o[1] && d == 1)  exp_lat = 2;
        else                       exp_lat = 33;
        op[d] = o; d1[d] = a; d2[d] = b; start[d] = 1'b1;
        #1;
        chk({name, "_stall_c0"}, {63'd0, stall[d]}, 64'd1);
        @(posedge clk); #1;
        lat = 1;
        if (!hold) start[d] = 1'b0;
        if (o[1]) chk({name, "_busy_c1"}, {63'd0, busy[d]}, {63'd0, (b != 32'd0)});
        else if (d == 0) chk({name, "_busy_c1"}, {63'd0, busy[d]}, 64'd1);
        stall_ok = 1'b1;
        while (!rdy[d] && lat < 100) begin
            if (!stall[d]) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_stall_run"}, {63'd0, stall_ok}, 64'd1);
        chk({name, "_result"}, res[d], exp);
        chk({name, "_dz"}, {63'd0, dzo[d]}, {63'd0, exp_dz});
        chk({name, "_stall_rdy"}, {63'd0, stall[d]}, 64'd0);
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk({name, "_rdy_pulse"}, {63'd0, rdy[d]}, 64'd0);
    endtask

    initial begin
        logic [64:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] prior;
        int          rp, bz;

        tbl[0] = '{2'b11, 32'd100,         32'd7,         64'h00000002_0000000E, 1'b0};
        tbl[1] = '{2'b10, 32'hFFFF_FFF9,   32'd2,         64'hFFFFFFFF_FFFFFFFD, 1'b0};
        tbl[2] = '{2'b10, 32'h8000_0000,   32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0};
        tbl[3] = '{2'b00, 32'hFFFF_FFFF,   32'd2,         64'hFFFFFFFF_FFFFFFFE, 1'b0};
        tbl[4] = '{2'b01, 32'hFFFF_FFFF,   32'd2,         64'h00000001_FFFFFFFE, 1'b0};
        tbl[5] = '{2'b10, 32'h1234_5678,   32'd0,         64'h12345678_FFFFFFFF, 1'b1};
        tbl[6] = '{2'b11, 32'd9,           32'd3,         64'h00000000_00000003, 1'b0};
        tbl[7] = '{2'b00, 32'h8000_0000,   32'h8000_0000, 64'h40000000_00000000, 1'b0};
        tbl[8] = '{2'b10, 32'd7,           32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0};
        tbl[9] = '{2'b11, 32'd5,           32'd0,         64'h00000005_FFFFFFFF, 1'b1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; op[d] = 2'b00; d1[d] = '0; d2[d] = '0; annul[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_result%0d", d), res[d], 64'd0);
            chk($sformatf("reset_flags%0d", d), {60'd0, rdy[d], dzo[d], busy[d], stall[d]}, 64'd0);
        end

        for (int i = 0; i < 10; i++)
            for (int d = 0; d < 2; d++)
                run_op(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].exp_dz, 1'b0,
                       $sformatf("vec%0d_dut%0d", i, d));

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            m = model(ro, ra, rb);
            for (int d = 0; d < 2; d++)
                run_op(d, ro, ra, rb, m[63:0], m[64], 1'b0, $sformatf("rnd%0d_dut%0d", i, d));
        end

        // Annul a DIVU in its tenth RUN cycle: no ready, result keeps the prior value.
        run_op(0, 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0, "annul_prior");
        prior = 64'h00000002_0000000E;
        op[0] = 2'b11; d1[0] = 32'd1000; d2[0] = 32'd7; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        annul[0] = 1'b1;
        @(posedge clk); #1;
        annul[0] = 1'b0;
        chk("annul_idle", {61'd0, busy[0], stall[0], rdy[0]}, 64'd0);
        rp = 0;
        repeat (40) begin @(posedge clk); #1; rp += int'(rdy[0]); end
        chk("annul_no_ready", 64'(rp), 64'd0);
        chk("annul_result_kept", res[0], prior);
        run_op(0, 2'b11, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 1'b0, "after_annul");

        // Synchronous reset in the middle of a slow multiply.
        op[0] = 2'b00; d1[0] = 32'd5; d2[0] = 32'd7; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_result", res[0], 64'd0);
        chk("midrun_rst_flags", {60'd0, rdy[0], dzo[0], busy[0], stall[0]}, 64'd0);
        chk("midrun_rst_other", res[1], 64'd0);
        run_op(0, 2'b00, 32'd5, 32'd7, 64'd35, 1'b0, 1'b0, "after_rst");

        // start_i held through DONE on both instances: one pulse, no restart.
        for (int d = 0; d < 2; d++) begin
            run_op(d, 2'b00, 32'hFFFF_FFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b1,
                   $sformatf("hold_dut%0d", d));
            rp = 0; bz = 0;
            repeat (10) begin
                @(posedge clk); #1;
                rp += int'(rdy[d]);
                bz += int'(busy[d]);
            end
            chk($sformatf("hold_no_second_ready%0d", d), 64'(rp), 64'd0);
            chk($sformatf("hold_no_restart%0d", d), 64'(bz), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
